// File: rtl/decomp_mlane.sv
`default_nettype none
// ============================================================================
//  Module      : decomp_mlane
//  Description : Multi-lane 65b -> 66b PCS block reconstruction feeding a
//                first-word-fall-through output FIFO with drop/control stats.
//  Revision    : 1.0  initial release
// ============================================================================
module decomp_mlane #(
    parameter int LANES      = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 32
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [65*LANES-1:0]           C_BLK,
    input  logic                          C_BLK_ENA,
    input  logic                          ENDIAN_SWAP,
    input  logic                          CLR_STATS,
    output logic [66*LANES-1:0]           PCS_BLK,
    output logic                          PCS_BLK_ENA,
    input  logic                          PCS_BLK_RDY,
    output logic [$clog2(FIFO_DEPTH):0]   LEVEL,
    output logic                          OVERFLOW,
    output logic [CNT_W-1:0]              DROP_CNT,
    output logic [CNT_W-1:0]              CTRL_CNT
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = $clog2(LANES + 1);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

    logic [66*LANES-1:0] wr_word;
    logic [LANES-1:0]    sbit;

    // ------------------------------------------------------------------
    // Per-lane transform: the 65-bit lane is fully reversed, so the sync
    // bit comes from original bits 64 and 55, and the payload is the
    // bit-reversed low 64 bits, optionally byte-swapped.
    // ------------------------------------------------------------------
    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            logic [64:0] c;
            logic [63:0] p_rev;
            logic [63:0] p_out;

            assign c = C_BLK[65*k +: 65];

            // Bit-reverse the payload, then optionally reverse byte order.
            always_comb begin
                p_rev = '0;
                for (int i = 0; i < 64; i++) begin
                    p_rev[i] = c[63-i];
                end
                p_out = p_rev;
                if (ENDIAN_SWAP) begin
                    for (int j = 0; j < 8; j++) begin
                        p_out[8*j +: 8] = p_rev[8*(7-j) +: 8];
                    end
                end
            end

            assign sbit[k] = c[64] ^ c[55];
            assign wr_word[66*k +: 66] = {p_out, sbit[k], ~sbit[k]};
        end
    endgenerate

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    logic [66*LANES-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [LW-1:0]       level;
    logic                not_empty;
    logic                full;
    logic                pop;
    logic                wr_en;
    logic                drop;

    assign not_empty = (level != '0);
    assign full      = (level == FULL_LEVEL);
    assign pop       = not_empty & PCS_BLK_RDY;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign wr_en     = C_BLK_ENA & (~full | pop);
    assign drop      = C_BLK_ENA & full & ~pop;

    // Storage array; stale contents are harmless because level gates reads.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_word;
        end
    end

    // Pointers wrap naturally (power-of-two depth); level disambiguates full/empty.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            level <= level + LW'(wr_en) - LW'(pop);
        end
    end

    assign LEVEL       = level;
    assign PCS_BLK_ENA = not_empty;
    assign PCS_BLK     = not_empty ? mem[rd_ptr] : '0;

    // ------------------------------------------------------------------
    // Statistics: clear first, then the same-cycle event is applied.
    // ------------------------------------------------------------------
    logic [CW-1:0]    ctrl_lanes;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] ctrl_cnt;
    logic             overflow;
    logic [CNT_W-1:0] drop_base;
    logic [CNT_W-1:0] ctrl_base;
    logic [CNT_W:0]   ctrl_sum;
    logic [CNT_W-1:0] drop_next;
    logic [CNT_W-1:0] ctrl_next;

    // Count lanes whose sync bit marks a control block.
    always_comb begin
        ctrl_lanes = '0;
        for (int k = 0; k < LANES; k++) begin
            ctrl_lanes = ctrl_lanes + CW'(~sbit[k]);
        end
    end

    // Saturating next values for both counters.
    always_comb begin
        drop_base = CLR_STATS ? '0 : drop_cnt;
        ctrl_base = CLR_STATS ? '0 : ctrl_cnt;
        ctrl_sum  = {1'b0, ctrl_base} + (CNT_W+1)'(ctrl_lanes);
        drop_next = drop_base;
        ctrl_next = ctrl_base;
        if (drop && (drop_base != '1)) begin
            drop_next = drop_base + CNT_W'(1);
        end
        if (wr_en) begin
            ctrl_next = ctrl_sum[CNT_W] ? '1 : ctrl_sum[CNT_W-1:0];
        end
    end

    // Statistics registers; reset has priority over clear and events.
    always_ff @(posedge CLK) begin
        if (RST) begin
            drop_cnt <= '0;
            ctrl_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            drop_cnt <= drop_next;
            ctrl_cnt <= ctrl_next;
            overflow <= (overflow & ~CLR_STATS) | drop;
        end
    end

    assign DROP_CNT = drop_cnt;
    assign CTRL_CNT = ctrl_cnt;
    assign OVERFLOW = overflow;

endmodule
`default_nettype wire

// File: tb/tb_decomp_mlane.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decomp_mlane
//  Description : Self-checking bench for decomp_mlane (1-lane and 4-lane
//                instances) with vector table, corner sequences and a
//                queue-based reference model under random stimulus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_decomp_mlane;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // single-lane instance
    logic        rst = 1'b1, cena = 1'b0, swap = 1'b0, clr = 1'b0, rdy = 1'b0;
    logic [64:0] cblk = '0;
    logic [65:0] blk;
    logic        ena, ovf;
    logic [2:0]  level;
    logic [31:0] dropc, ctrlc;

    decomp_mlane #(.LANES(1), .FIFO_DEPTH(DEPTH), .CNT_W(32)) dut1 (
        .CLK(clk), .RST(rst), .C_BLK(cblk), .C_BLK_ENA(cena),
        .ENDIAN_SWAP(swap), .CLR_STATS(clr), .PCS_BLK(blk),
        .PCS_BLK_ENA(ena), .PCS_BLK_RDY(rdy), .LEVEL(level),
        .OVERFLOW(ovf), .DROP_CNT(dropc), .CTRL_CNT(ctrlc));

    // four-lane instance with narrow counters to reach saturation
    logic         rst2 = 1'b1, cena2 = 1'b0, rdy2 = 1'b0;
    logic [259:0] cblk2 = '0;
    logic [263:0] blk2;
    logic         ena2, ovf2;
    logic [2:0]   level2;
    logic [3:0]   drop2, ctrl2;

    decomp_mlane #(.LANES(4), .FIFO_DEPTH(DEPTH), .CNT_W(4)) dut2 (
        .CLK(clk), .RST(rst2), .C_BLK(cblk2), .C_BLK_ENA(cena2),
        .ENDIAN_SWAP(1'b0), .CLR_STATS(1'b0), .PCS_BLK(blk2),
        .PCS_BLK_ENA(ena2), .PCS_BLK_RDY(rdy2), .LEVEL(level2),
        .OVERFLOW(ovf2), .DROP_CNT(drop2), .CTRL_CNT(ctrl2));

    int total = 0;
    int bad   = 0;

    // reference model state for dut1
    logic [65:0] mq[$];
    longint      m_drop = 0, m_ctrl = 0;
    bit          m_ovf = 1'b0;

    // Lane rule from the block definition: reverse, sync bit, payload, swap.
    function automatic logic [65:0] ref_lane(input logic [64:0] c, input logic sw);
        logic [64:0] r;
        logic [63:0] p, q;
        logic        s;
        for (int i = 0; i < 65; i++) r[i] = c[64-i];
        s = r[0] ^ r[9];
        p = r[64:1];
        q = p;
        if (sw) for (int j = 0; j < 8; j++) q[8*j +: 8] = p[8*(7-j) +: 8];
        return {q, s, ~s};
    endfunction

    function automatic logic [64:0] rnd65();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[64:0];
    endfunction

    task automatic chk(input string name, input logic [263:0] act, input logic [263:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Apply the current dut1 inputs to the model, then advance one clock.
    task automatic tick();
        bit          pop;
        logic [65:0] w;
        if (rst) begin
            mq.delete();
            m_drop = 0; m_ctrl = 0; m_ovf = 1'b0;
        end else begin
            pop = rdy && (mq.size() > 0);
            if (clr) begin
                m_drop = 0; m_ctrl = 0; m_ovf = 1'b0;
            end
            if (pop) void'(mq.pop_front());
            if (cena) begin
                w = ref_lane(cblk, swap);
                if (mq.size() < DEPTH) begin
                    mq.push_back(w);
                    if (w[0] && m_ctrl < 64'hFFFF_FFFF) m_ctrl++;
                end else begin
                    if (m_drop < 64'hFFFF_FFFF) m_drop++;
                    m_ovf = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".level"}, level, mq.size());
        chk({tag, ".ena"},   ena,   mq.size() != 0);
        chk({tag, ".blk"},   blk,   (mq.size() != 0) ? mq[0] : 66'h0);
        chk({tag, ".drop"},  dropc, m_drop);
        chk({tag, ".ctrl"},  ctrlc, m_ctrl);
        chk({tag, ".ovf"},   ovf,   m_ovf);
    endtask

    typedef struct {
        logic [64:0] c;
        logic        sw;
        logic [65:0] exp;
        int          ctrl;
    } vec_t;

    vec_t        vt[7];
    logic [64:0] w6[6];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{65'h0,                   1'b0, 66'h1,                     1};
        vt[1] = '{65'h1_0000_0000_0000_0000, 1'b0, 66'h2,                   1};
        vt[2] = '{65'h0_0080_0000_0000_0000, 1'b0, 66'h402,                 1};
        vt[3] = '{65'h1,                   1'b0, 66'h2_0000_0000_0000_0001, 2};
        vt[4] = '{65'h1,                   1'b1, 66'h201,                   3};
        vt[5] = '{65'h1_0080_0000_0000_0000, 1'b0, 66'h401,                 4};
        vt[6] = '{65'h0_8000_0000_0000_0000, 1'b1, 66'h0_0400_0000_0000_0001, 5};

        // reset state
        #1;
        tick(); tick();
        check_all("reset");
        chk("reset2.level", level2, 0);
        chk("reset2.ena",   ena2,   0);
        chk("reset2.blk",   blk2,   0);
        chk("reset2.drop",  drop2,  0);
        chk("reset2.ctrl",  ctrl2,  0);
        chk("reset2.ovf",   ovf2,   0);
        rst = 1'b0; rst2 = 1'b0;

        // table of single-lane transform vectors, one word at a time
        rdy = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cblk = vt[i].c; swap = vt[i].sw; cena = 1'b1;
            tick();
            cena = 1'b0; swap = 1'b0;
            chk("vec.blk",  blk,   vt[i].exp);
            chk("vec.ena",  ena,   1);
            chk("vec.ctrl", ctrlc, vt[i].ctrl);
            tick();
            chk("vec.level", level, 0);
        end
        check_all("vec_end");

        // six writes into a stalled FIFO: two drops, then ordered drain
        rdy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            w6[i] = rnd65(); cblk = w6[i]; cena = 1'b1;
            tick();
        end
        cena = 1'b0;
        chk("ovf.level", level, 4);
        chk("ovf.drop",  dropc, 2);
        chk("ovf.flag",  ovf,   1);
        check_all("ovf");
        rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("pop_order", blk, ref_lane(w6[i], 1'b0));
            tick();
        end
        chk("drained.ena", ena, 0);
        chk("drained.blk", blk, 0);

        // full FIFO with simultaneous write and pop, then clear plus drop
        rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cblk = rnd65(); cena = 1'b1;
            tick();
        end
        rdy = 1'b1; cblk = rnd65();
        tick();
        chk("wrpop.level", level, 4);
        chk("wrpop.drop",  dropc, 2);
        check_all("wrpop");
        rdy = 1'b0; clr = 1'b1; cblk = rnd65();
        tick();
        clr = 1'b0; cena = 1'b0;
        chk("clrdrop.drop", dropc, 1);
        chk("clrdrop.ovf",  ovf,   1);
        check_all("clrdrop");
        rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_all("drain");
        end

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            cblk = rnd65();
            if ($urandom_range(0, 3) == 0) cblk[55] = cblk[64];
            cena = ($urandom_range(0, 3) != 0);
            rdy  = ($urandom_range(0, 5) < (n / 100));
            swap = $urandom_range(0, 1) == 1;
            clr  = ($urandom_range(0, 40) == 0);
            rst  = ($urandom_range(0, 120) == 0);
            tick();
            check_all("rand");
        end
        rst = 1'b0; clr = 1'b0; cena = 1'b0; swap = 1'b0; rdy = 1'b1;
        tick(); tick(); tick(); tick(); tick();

        // mid-operation reset, then latency of the first new word
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cblk = rnd65(); cena = 1'b1;
            tick();
        end
        cena = 1'b0;
        chk("midrst.pre_level", level, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst.level", level, 0);
        chk("midrst.ena",   ena,   0);
        cblk = '0; cena = 1'b1;
        tick();
        cena = 1'b0;
        chk("midrst.lat_ena", ena, 1);
        chk("midrst.lat_blk", blk, 66'h1);
        check_all("midrst");

        // four lanes of zero: each lane 66'h1 and CTRL_CNT += 4
        cblk2 = '0; cena2 = 1'b1; rdy2 = 1'b1;
        tick();
        cena2 = 1'b0;
        for (int k = 0; k < 4; k++) chk("lane4.blk", blk2[66*k +: 66], 66'h1);
        chk("lane4.ctrl", ctrl2, 4);
        tick();
        rdy2 = 1'b0; cena2 = 1'b1;
        tick(); tick(); tick();
        cena2 = 1'b0;
        chk("lane4.level", level2, 3);
        chk("lane4.ctrl_sat", ctrl2, 15);
        rst2 = 1'b1;
        tick();
        rst2 = 1'b0;
        chk("lane4.rst_level", level2, 0);
        chk("lane4.rst_ena",   ena2,   0);
        chk("lane4.rst_blk",   blk2,   0);
        chk("lane4.rst_ctrl",  ctrl2,  0);
        cena2 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cblk2 = {rnd65(), rnd65(), rnd65(), rnd65()};
            tick();
        end
        cena2 = 1'b0;
        chk("lane4.drop_sat", drop2,  15);
        chk("lane4.ovf",      ovf2,   1);
        chk("lane4.full",     level2, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
